// File: rtl/wb_mem_responder.sv
`timescale 1ns/1ps
// wb_mem_responder
// -----------------------------------------------------------------------------
// Wishbone B4 pipelined responder backed by an internal word-addressed RAM.
// Requests are queued and answered strictly in order. Each answer comes
// LATENCY cycles after its request reaches the head of the queue.
//
// Ports
//   clk_i       rising-edge clock
//   rst_i       asynchronous reset, active low
//   wb_adr_i    byte address; word index = wb_adr_i[DEPTH_W+1:2]
//   wb_dat_i    write data
//   wb_dat_o    read data; zero whenever wb_ack_o is low
//   wb_sel_i    byte lane enables (bit n covers bits [8n+7:8n])
//   wb_we_i     1 = write, 0 = read
//   wb_stb_i    request strobe
//   wb_cyc_i    bus cycle active; low at an edge flushes all pending work
//   wb_ack_o    one-cycle acknowledge per accepted request
//   wb_stall_o  high when the request queue is full
//   dbg_state   current head-processing FSM state (debug)
//
// Handshake: a request transfers on a rising edge where
//   wb_cyc_i & wb_stb_i & !wb_stall_o.
// wb_stall_o depends only on the registered queue count, so the master may
// sample it at any point in the cycle without a combinational loop through
// the bus inputs.
// -----------------------------------------------------------------------------
module wb_mem_responder #(
  parameter int DEPTH_W    = 10,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic [1:0]  dbg_state
);

  localparam int MEM_WORDS = 2 ** DEPTH_W;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W     = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  // Last value of the wait counter before moving to RESP; WAIT spends
  // LATENCY-1 edges, so counting from 0 it ends at LATENCY-2.
  localparam logic [LAT_W-1:0] WAIT_LAST = LAT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // State an entry enters when it becomes the head of the queue.
  localparam state_t HEAD_STATE = (LATENCY == 1) ? ST_RESP : ST_WAIT;

  // Request queue storage (no reset needed: validity is tracked by count)
  logic [DEPTH_W-1:0] q_idx [FIFO_DEPTH];
  logic [31:0]        q_dat [FIFO_DEPTH];
  logic [3:0]         q_sel [FIFO_DEPTH];
  logic               q_we  [FIFO_DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  state_t             state;
  logic [LAT_W-1:0]   wait_cnt;

  logic [31:0]        mem [MEM_WORDS];

  logic               push;
  logic               pop;
  logic               more_after_pop;
  logic [DEPTH_W-1:0] req_idx;
  logic [DEPTH_W-1:0] head_idx;
  logic [31:0]        head_dat;
  logic [3:0]         head_sel;
  logic               head_we;

  // Address bits outside the word index are intentionally ignored.
  logic               unused_adr_bits;
  assign unused_adr_bits = ^{wb_adr_i[31:DEPTH_W+2], wb_adr_i[1:0]};

  assign req_idx    = wb_adr_i[DEPTH_W+1:2];
  assign wb_stall_o = (count == CNT_W'(FIFO_DEPTH));
  assign push       = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  // The head is serviced on the edge that leaves RESP; an abort on that
  // same edge wins, so the access is dropped.
  assign pop        = wb_cyc_i & (state == ST_RESP);

  assign head_idx   = q_idx[rd_ptr];
  assign head_dat   = q_dat[rd_ptr];
  assign head_sel   = q_sel[rd_ptr];
  assign head_we    = q_we[rd_ptr];

  // Queue is non-empty after this edge's pop when more than the head was
  // stored or a new request arrives on the same edge.
  assign more_after_pop = (count > CNT_W'(1)) | push;

  assign dbg_state = state;

  // Queue payload write
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_idx[wr_ptr] <= req_idx;
      q_dat[wr_ptr] <= wb_dat_i;
      q_sel[wr_ptr] <= wb_sel_i;
      q_we[wr_ptr]  <= wb_we_i;
    end
  end

  // RAM write with byte lanes; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (pop && head_we) begin
      for (int b = 0; b < 4; b++) begin
        if (head_sel[b]) begin
          mem[head_idx][8*b +: 8] <= head_dat[8*b +: 8];
        end
      end
    end
  end

  // Queue bookkeeping, head FSM and registered response
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else if (!wb_cyc_i) begin
      // Abort: drop every pending request, including unacked writes.
      state    <= ST_IDLE;
      wait_cnt <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      wb_ack_o <= pop;
      wb_dat_o <= (pop && !head_we) ? mem[head_idx] : '0;

      case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (push) begin
            state <= HEAD_STATE;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            state    <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + LAT_W'(1);
          end
        end
        ST_RESP: begin
          wait_cnt <= '0;
          state    <= more_after_pop ? HEAD_STATE : ST_IDLE;
        end
        default: begin
          wait_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
